// File: rtl/net_pkg.sv
// Shared Ethernet/AXI-Stream constants and the frame drop-reason encoding
// for the receive path.
package net_pkg;

  localparam int unsigned ETH_MIN_FRAME_BYTES = 60;
  localparam int unsigned ETH_MAX_FRAME_BYTES = 1514;

  localparam int unsigned AXIS_DATA_WIDTH = 512;
  localparam int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    OVERFLOW = 3'd1,
    FCS      = 3'd2,
    OVERSIZE = 3'd3,
    RUNT     = 3'd4
  } drop_reason_t;

endpackage

// File: rtl/rx_frame_buf_ram.sv
// Simple dual-port frame buffer: one write port and one registered read port
// on the same clock. The read register only updates when rd_en is high.
module rx_frame_buf_ram #(
  parameter int unsigned WIDTH  = 577,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rx_frame_filter_fifo.sv
// Store-and-forward RX frame FIFO: a frame becomes visible only once its last beat
// is accepted and it is legal; runt, oversize, bad-FCS and overflowing frames are dropped.
module rx_frame_filter_fifo
  import net_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned MIN_BYTES  = ETH_MIN_FRAME_BYTES,
  parameter int unsigned MAX_BYTES  = ETH_MAX_FRAME_BYTES
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [31:0]             cnt_frames_ok,
  output logic [31:0]             cnt_drop_runt,
  output logic [31:0]             cnt_drop_oversize,
  output logic [31:0]             cnt_drop_fcs,
  output logic [31:0]             cnt_drop_overflow
);

  localparam int unsigned KEEP_W  = DATA_WIDTH / 8;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = DATA_WIDTH + KEEP_W + 1;

  localparam logic [15:0]   MIN_LEN = 16'(MIN_BYTES);
  localparam logic [15:0]   MAX_LEN = 16'(MAX_BYTES);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [0:0] ACCEPT  = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  logic [0:0]    wr_state;
  drop_reason_t  discard_reason;
  logic [15:0]   bytecnt;
  logic [15:0]   beat_bytes;
  logic [15:0]   frame_bytes;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_inc;
  logic [AW-1:0] wr_commit;
  logic [AW-1:0] rd_ptr;
  logic          full;

  logic          wr_en;
  logic          commit;
  logic          drop;
  drop_reason_t  drop_reason;
  logic          go_discard;
  drop_reason_t  new_reason;

  logic               ram_valid;
  logic               out_load;
  logic               rd_en;
  logic [ENTRY_W-1:0] ram_q;

  assign s_axis_tready = 1'b1;

  assign wr_ptr_inc = wr_ptr + PTR_ONE;
  // Uses the pre-cycle rd_ptr, so a read in this same cycle is not credited.
  assign full       = (wr_ptr_inc == rd_ptr);

  always_comb begin
    beat_bytes = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + 16'(s_axis_tkeep[i]);
    end
  end

  assign frame_bytes = bytecnt + beat_bytes;

  // Per-beat verdict; the tlast checks run in the fixed priority order below.
  always_comb begin
    wr_en       = 1'b0;
    commit      = 1'b0;
    drop        = 1'b0;
    drop_reason = NONE;
    go_discard  = 1'b0;
    new_reason  = NONE;
    if (s_axis_tvalid) begin
      if (wr_state == DISCARD) begin
        if (s_axis_tlast) begin
          drop        = 1'b1;
          drop_reason = discard_reason;
        end
      end else if (s_axis_tlast) begin
        drop = 1'b1;
        if (full) begin
          drop_reason = OVERFLOW;
        end else if (s_axis_tuser) begin
          drop_reason = FCS;
        end else if (frame_bytes > MAX_LEN) begin
          drop_reason = OVERSIZE;
        end else if (frame_bytes < MIN_LEN) begin
          drop_reason = RUNT;
        end else begin
          drop   = 1'b0;
          wr_en  = 1'b1;
          commit = 1'b1;
        end
      end else if (full) begin
        go_discard = 1'b1;
        new_reason = OVERFLOW;
      end else if (frame_bytes > MAX_LEN) begin
        go_discard = 1'b1;
        new_reason = OVERSIZE;
      end else begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state          <= ACCEPT;
      discard_reason    <= NONE;
      bytecnt           <= '0;
      wr_ptr            <= '0;
      wr_commit         <= '0;
      cnt_frames_ok     <= '0;
      cnt_drop_runt     <= '0;
      cnt_drop_oversize <= '0;
      cnt_drop_fcs      <= '0;
      cnt_drop_overflow <= '0;
    end else begin
      if (commit) begin
        wr_ptr    <= wr_ptr_inc;
        wr_commit <= wr_ptr_inc;
      end else if (drop) begin
        wr_ptr <= wr_commit;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr_inc;
      end

      if (go_discard) begin
        wr_state       <= DISCARD;
        discard_reason <= new_reason;
      end else if (drop) begin
        wr_state <= ACCEPT;
      end

      if (s_axis_tvalid) begin
        if (s_axis_tlast) begin
          bytecnt <= '0;
        end else if (wr_state == ACCEPT) begin
          bytecnt <= frame_bytes;
        end
      end

      if (commit) begin
        cnt_frames_ok <= cnt_frames_ok + 32'd1;
      end
      if (drop) begin
        case (drop_reason)
          OVERFLOW: cnt_drop_overflow <= cnt_drop_overflow + 32'd1;
          FCS:      cnt_drop_fcs      <= cnt_drop_fcs + 32'd1;
          OVERSIZE: cnt_drop_oversize <= cnt_drop_oversize + 32'd1;
          RUNT:     cnt_drop_runt     <= cnt_drop_runt + 32'd1;
          default:  ;
        endcase
      end
    end
  end

  rx_frame_buf_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  // Two-slot read pipeline: the RAM read register acts as the skid slot behind
  // the output register, so a new read is issued whenever a slot frees up.
  assign out_load = ram_valid && (!m_axis_tvalid || m_axis_tready);
  assign rd_en    = (rd_ptr != wr_commit) && (!ram_valid || out_load);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_ptr        <= '0;
      ram_valid     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      ram_valid <= rd_en || (ram_valid && !out_load);
      if (out_load) begin
        m_axis_tvalid                              <= 1'b1;
        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= ram_q;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_filter_fifo.sv
// Randomized bench for rx_frame_filter_fifo with a frame-level reference model
// and a small-depth instance for the overflow scenario.
module tb_rx_frame_filter_fifo;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;

  logic         s_valid, s_ready, s_last, s_user;
  logic [511:0] s_data;
  logic [63:0]  s_keep;
  logic         m_valid, m_ready, m_last;
  logic [511:0] m_data;
  logic [63:0]  m_keep;
  logic [31:0]  cnt_ok, cnt_runt, cnt_over, cnt_fcs, cnt_ovf;

  logic         s16_valid, s16_ready, s16_last, s16_user;
  logic [511:0] s16_data;
  logic [63:0]  s16_keep;
  logic         m16_valid, m16_ready, m16_last;
  logic [511:0] m16_data;
  logic [63:0]  m16_keep;
  logic [31:0]  c16_ok, c16_runt, c16_over, c16_fcs, c16_ovf;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  beat_t       exp_q[$];
  beat_t       exp16_q[$];
  int unsigned exp_ok, exp_runt, exp_over, exp_fcs, exp_ovf;
  int unsigned beats16 = 0;
  int unsigned lasts16 = 0;
  bit          ready_random = 1'b0;

  rx_frame_filter_fifo dut (
    .aclk              (clk),
    .aresetn           (aresetn),
    .s_axis_tvalid     (s_valid),
    .s_axis_tready     (s_ready),
    .s_axis_tdata      (s_data),
    .s_axis_tkeep      (s_keep),
    .s_axis_tlast      (s_last),
    .s_axis_tuser      (s_user),
    .m_axis_tvalid     (m_valid),
    .m_axis_tready     (m_ready),
    .m_axis_tdata      (m_data),
    .m_axis_tkeep      (m_keep),
    .m_axis_tlast      (m_last),
    .cnt_frames_ok     (cnt_ok),
    .cnt_drop_runt     (cnt_runt),
    .cnt_drop_oversize (cnt_over),
    .cnt_drop_fcs      (cnt_fcs),
    .cnt_drop_overflow (cnt_ovf)
  );

  rx_frame_filter_fifo #(
    .DEPTH     (16),
    .MAX_BYTES (900)
  ) dut16 (
    .aclk              (clk),
    .aresetn           (aresetn),
    .s_axis_tvalid     (s16_valid),
    .s_axis_tready     (s16_ready),
    .s_axis_tdata      (s16_data),
    .s_axis_tkeep      (s16_keep),
    .s_axis_tlast      (s16_last),
    .s_axis_tuser      (s16_user),
    .m_axis_tvalid     (m16_valid),
    .m_axis_tready     (m16_ready),
    .m_axis_tdata      (m16_data),
    .m_axis_tkeep      (m16_keep),
    .m_axis_tlast      (m16_last),
    .cnt_frames_ok     (c16_ok),
    .cnt_drop_runt     (c16_runt),
    .cnt_drop_oversize (c16_over),
    .cnt_drop_fcs      (c16_fcs),
    .cnt_drop_overflow (c16_ovf)
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level rules: a frame whose full non-last beats already exceed the
  // maximum is oversize regardless of FCS; otherwise fcs > oversize > runt > ok.
  function automatic void model_frame(input int len, input bit fcs, input beat_t beats[$]);
    int bytes_before_last = (beats.size() - 1) * 64;
    if (bytes_before_last > 1514)  exp_over++;
    else if (fcs)                  exp_fcs++;
    else if (len > 1514)           exp_over++;
    else if (len < 60)             exp_runt++;
    else begin
      exp_ok++;
      foreach (beats[i]) exp_q.push_back(beats[i]);
    end
  endfunction

  task automatic send_frame(input int len, input bit fcs, input bit gaps);
    beat_t beats[$];
    int n = (len + 63) / 64;
    for (int b = 0; b < n; b++) begin
      beat_t bt;
      int nb = (b == n - 1) ? len - 64 * b : 64;
      while (gaps && $urandom_range(0, 4) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      for (int w = 0; w < 16; w++) bt.data[w*32 +: 32] = $urandom();
      bt.keep = '0;
      for (int i = 0; i < nb; i++) bt.keep[i] = 1'b1;
      bt.last = (b == n - 1);
      s_valid = 1'b1;
      s_data  = bt.data;
      s_keep  = bt.keep;
      s_last  = bt.last;
      s_user  = bt.last ? fcs : 1'($urandom_range(0, 1));
      beats.push_back(bt);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_user  = 1'b0;
    model_frame(len, fcs, beats);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain", 512'(exp_q.size()), 512'd0);
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_ok"},   512'(cnt_ok),   512'(exp_ok));
    check_eq({tag, "_runt"}, 512'(cnt_runt), 512'(exp_runt));
    check_eq({tag, "_over"}, 512'(cnt_over), 512'(exp_over));
    check_eq({tag, "_fcs"},  512'(cnt_fcs),  512'(exp_fcs));
    check_eq({tag, "_ovf"},  512'(cnt_ovf),  512'(exp_ovf));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 512'(m_valid), 512'd0);
    check_eq({tag, "_data"},  m_data,        512'd0);
    check_eq({tag, "_keep"},  512'(m_keep),  512'd0);
    check_eq({tag, "_last"},  512'(m_last),  512'd0);
    exp_ok = 0; exp_runt = 0; exp_over = 0; exp_fcs = 0; exp_ovf = 0;
    check_counters(tag);
  endtask

  beat_t mon_e;
  beat_t prev;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 512'(m_valid), 512'd1);
        check_eq("hold_data",  m_data,        prev.data);
        check_eq("hold_keep",  512'(m_keep),  512'(prev.keep));
        check_eq("hold_last",  512'(m_last),  512'(prev.last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 512'(m_valid), 512'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out_data", m_data,       mon_e.data);
          check_eq("out_keep", 512'(m_keep), 512'(mon_e.keep));
          check_eq("out_last", 512'(m_last), 512'(mon_e.last));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev.data  = m_data;
      prev.keep  = m_keep;
      prev.last  = m_last;
    end
  end

  beat_t mon16_e;
  always @(negedge clk) begin
    if (aresetn && m16_valid && m16_ready) begin
      beats16++;
      if (m16_last) lasts16++;
      if (exp16_q.size() == 0) begin
        check_eq("dut16_extra", 512'(m16_valid), 512'd0);
      end else begin
        mon16_e = exp16_q.pop_front();
        check_eq("dut16_data", m16_data,       mon16_e.data);
        check_eq("dut16_last", 512'(m16_last), 512'(mon16_e.last));
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = ready_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn   = 1'b0;
    s_valid   = 1'b0; s_data   = '0; s_keep   = '0; s_last   = 1'b0; s_user   = 1'b0;
    s16_valid = 1'b0; s16_data = '0; s16_keep = '0; s16_last = 1'b0; s16_user = 1'b0;
    m16_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    check_eq("s_ready", 512'(s_ready), 512'd1);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // single full beat: valid appears exactly two cycles after tlast is taken
    send_frame(64, 1'b0, 1'b0);
    check_eq("lat_c0", 512'(m_valid), 512'd0);
    @(posedge clk); #1;
    check_eq("lat_c1", 512'(m_valid), 512'd0);
    @(posedge clk); #1;
    check_eq("lat_c2", 512'(m_valid), 512'd1);
    wait_drain();
    check_counters("single");

    send_frame(40, 1'b0, 1'b0);
    send_frame(60, 1'b0, 1'b0);
    wait_drain();
    check_counters("runt");

    send_frame(1519, 1'b0, 1'b0);
    send_frame(128, 1'b0, 1'b0);
    wait_drain();
    check_counters("oversize");

    send_frame(256, 1'b1, 1'b0);
    send_frame(64, 1'b0, 1'b0);
    wait_drain();
    check_counters("fcs");

    // small buffer, no drain: third frame cannot fit and must be dropped
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 6; b++) begin
        beat_t bt;
        for (int w = 0; w < 16; w++) bt.data[w*32 +: 32] = $urandom();
        bt.keep   = '1;
        bt.last   = (b == 5);
        s16_valid = 1'b1;
        s16_data  = bt.data;
        s16_keep  = bt.keep;
        s16_last  = bt.last;
        if (f < 2) exp16_q.push_back(bt);
        @(posedge clk); #1;
      end
    end
    s16_valid = 1'b0;
    s16_last  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("ovf_ok",    512'(c16_ok),   512'd2);
    check_eq("ovf_drop",  512'(c16_ovf),  512'd1);
    check_eq("ovf_runt",  512'(c16_runt), 512'd0);
    check_eq("ovf_fcs",   512'(c16_fcs),  512'd0);
    check_eq("ovf_over",  512'(c16_over), 512'd0);
    check_eq("ovf_held",  512'(beats16),  512'd0);
    check_eq("ovf_valid", 512'(m16_valid), 512'd1);
    m16_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("ovf_beats", 512'(beats16), 512'd12);
    check_eq("ovf_lasts", 512'(lasts16), 512'd2);
    check_eq("ovf_left",  512'(exp16_q.size()), 512'd0);

    // randomized traffic with gaps and random back-pressure
    ready_random = 1'b1;
    for (int k = 0; k < 120; k++) begin
      int len;
      bit fcs;
      int guard = 0;
      while (exp_q.size() > 400 && guard < 5000) begin
        @(posedge clk); #1;
        guard++;
      end
      case ($urandom_range(0, 9))
        0, 1:    len = $urandom_range(1, 59);
        2:       len = $urandom_range(1515, 1700);
        default: len = $urandom_range(60, 1514);
      endcase
      fcs = ($urandom_range(0, 6) == 0);
      send_frame(len, fcs, 1'b1);
    end
    wait_drain();
    check_counters("random");

    // reset in the middle of a 5-beat frame
    ready_random = 1'b0;
    wait_drain();
    for (int b = 0; b < 2; b++) begin
      s_valid = 1'b1;
      s_data  = {16{$urandom()}};
      s_keep  = '1;
      s_last  = 1'b0;
      @(posedge clk); #1;
    end
    s_data  = {16{$urandom()}};
    aresetn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    exp_q.delete();
    check_reset_state("midreset");
    aresetn = 1'b1;
    send_frame(64 + int'($urandom_range(1, 64)), 1'b0, 1'b0);
    send_frame(300, 1'b0, 1'b0);
    wait_drain();
    check_counters("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
